// File: rtl/ysyx_25040111_mem_pkg.sv
// Shared encodings for the ysyx_25040111 request arbiter and its memory port.
// Holds the controller state encoding and the access-size (mask) codes.
package ysyx_25040111_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    MASK_BYTE = 2'b00,
    MASK_HALF = 2'b01,
    MASK_WORD = 2'b10
  } mem_mask_e;

  localparam int LEN_W = 8;

endpackage

// File: rtl/ysyx_25040111_rr_pick.sv
// Round-robin selector: scans from i_ptr+1 upward (wrapping) and returns
// a one-hot grant for the first valid requester, or zero if none is valid.
module ysyx_25040111_rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant
);

  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    // k = NREQ lands back on ptr itself, so the last owner is checked last
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = PW'((int'(i_ptr) + k) % NREQ);
      if (!w_found && i_valid[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_25040111_rr_arbiter.sv
// N-way requester arbiter in front of a single read/write memory port.
// Arbitrates in IDLE, then runs one read burst or one write to completion.
module ysyx_25040111_rr_arbiter
  import ysyx_25040111_mem_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ*2-1:0]    req_mask,
  input  logic [NREQ*LEN_W-1:0] req_len,
  output logic [NREQ-1:0]      rsp_valid,
  output logic                 rsp_last,
  output logic [DW-1:0]        rsp_data,
  output logic                 mem_rvalid,
  input  logic                 mem_rready,
  output logic [AW-1:0]        mem_raddr,
  output logic [LEN_W-1:0]     mem_rlen,
  output logic [1:0]           mem_rmask,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 mem_wvalid,
  input  logic                 mem_wready,
  output logic [AW-1:0]        mem_waddr,
  output logic [DW-1:0]        mem_wdata,
  output logic [1:0]           mem_wmask
);

  localparam int PW = $clog2(NREQ);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_owner;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic [1:0]       r_mask;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;

  logic [NREQ-1:0]  w_rr_grant;
  logic [NREQ-1:0]  w_fix_grant;
  logic [NREQ-1:0]  w_grant;
  logic [PW-1:0]    w_win_idx;
  logic             w_sel_write;
  logic [AW-1:0]    w_sel_addr;
  logic [DW-1:0]    w_sel_wdata;
  logic [1:0]       w_sel_mask;
  logic [LEN_W-1:0] w_sel_len;
  logic             w_accept;
  logic             w_beat;

  ysyx_25040111_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant)
  );

  // Lowest set bit of req_valid: index 0 has the highest priority
  assign w_fix_grant = req_valid & (~req_valid + NREQ'(1));
  assign w_grant     = (PRIO_MODE != 0) ? w_fix_grant : w_rr_grant;

  always_comb begin
    w_win_idx   = '0;
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_mask  = '0;
    w_sel_len   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_win_idx   = PW'(i);
        w_sel_write = req_write[i];
        w_sel_addr  = req_addr[i*AW +: AW];
        w_sel_wdata = req_wdata[i*DW +: DW];
        w_sel_mask  = req_mask[i*2 +: 2];
        w_sel_len   = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_last    = 1'b0;
    rsp_data    = '0;
    mem_rvalid  = 1'b0;
    mem_wvalid  = 1'b0;
    w_accept    = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // No grant while reset is held so nothing is handed out mid-reset
        req_ready = reset ? w_grant : '0;
        w_accept  = |req_ready;
        if (w_accept) begin
          w_state_nxt = w_sel_write ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        mem_rvalid = 1'b1;
        if (mem_rready) begin
          w_beat             = 1'b1;
          rsp_valid[r_owner] = 1'b1;
          rsp_data           = mem_rdata;
          rsp_last           = (r_cnt == r_len);
          if (r_cnt == r_len) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_WR: begin
        mem_wvalid = 1'b1;
        if (mem_wready) begin
          rsp_valid[r_owner] = 1'b1;
          rsp_last           = 1'b1;
          w_state_nxt        = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_owner <= w_win_idx;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
      r_mask  <= w_sel_mask;
      r_len   <= w_sel_len;
      r_cnt   <= '0;
      if (PRIO_MODE == 0) begin
        r_ptr <= w_win_idx;
      end
    end else if (w_beat) begin
      r_cnt <= r_cnt + LEN_W'(1);
    end
  end

  assign mem_raddr = r_addr;
  assign mem_rlen  = r_len;
  assign mem_rmask = r_mask;
  assign mem_waddr = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_mask;

endmodule

// File: tb/tb_ysyx_25040111_rr_arbiter.sv
// Bench for the request arbiter: a 2-way round-robin instance driven from a
// vector table with a response scoreboard, plus a 3-way fixed-priority instance.
module tb_ysyx_25040111_rr_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  // 2-requester round-robin instance
  logic [1:0]  a_req_valid, a_req_ready, a_req_write, a_rsp_valid;
  logic [63:0] a_req_addr, a_req_wdata;
  logic [3:0]  a_req_mask;
  logic [15:0] a_req_len;
  logic        a_rsp_last, a_mem_rvalid, a_mem_rready, a_mem_wvalid, a_mem_wready;
  logic [31:0] a_rsp_data, a_mem_raddr, a_mem_rdata, a_mem_waddr, a_mem_wdata;
  logic [7:0]  a_mem_rlen;
  logic [1:0]  a_mem_rmask, a_mem_wmask;

  // 3-requester fixed-priority instance
  logic [2:0]  b_req_valid, b_req_ready, b_req_write, b_rsp_valid;
  logic [95:0] b_req_addr, b_req_wdata;
  logic [5:0]  b_req_mask;
  logic [23:0] b_req_len;
  logic        b_rsp_last, b_mem_rvalid, b_mem_rready, b_mem_wvalid, b_mem_wready;
  logic [31:0] b_rsp_data, b_mem_raddr, b_mem_rdata, b_mem_waddr, b_mem_wdata;
  logic [7:0]  b_mem_rlen;
  logic [1:0]  b_mem_rmask, b_mem_wmask;

  ysyx_25040111_rr_arbiter #(.NREQ(2), .AW(32), .DW(32), .PRIO_MODE(0)) dut_rr (
    .clock(clock), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_mask(a_req_mask), .req_len(a_req_len),
    .rsp_valid(a_rsp_valid), .rsp_last(a_rsp_last), .rsp_data(a_rsp_data),
    .mem_rvalid(a_mem_rvalid), .mem_rready(a_mem_rready), .mem_raddr(a_mem_raddr),
    .mem_rlen(a_mem_rlen), .mem_rmask(a_mem_rmask), .mem_rdata(a_mem_rdata),
    .mem_wvalid(a_mem_wvalid), .mem_wready(a_mem_wready), .mem_waddr(a_mem_waddr),
    .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask)
  );

  ysyx_25040111_rr_arbiter #(.NREQ(3), .AW(32), .DW(32), .PRIO_MODE(1)) dut_fx (
    .clock(clock), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_mask(b_req_mask), .req_len(b_req_len),
    .rsp_valid(b_rsp_valid), .rsp_last(b_rsp_last), .rsp_data(b_rsp_data),
    .mem_rvalid(b_mem_rvalid), .mem_rready(b_mem_rready), .mem_raddr(b_mem_raddr),
    .mem_rlen(b_mem_rlen), .mem_rmask(b_mem_rmask), .mem_rdata(b_mem_rdata),
    .mem_wvalid(b_mem_wvalid), .mem_wready(b_mem_wready), .mem_waddr(b_mem_waddr),
    .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a, input int b);
    return a ^ (32'h0101_0101 * 32'(b + 1));
  endfunction

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] data;
    logic        last;
  } rsp_t;

  rsp_t sbq[$];
  rsp_t mon_e;

  always @(negedge clock) begin
    if (a_rsp_valid !== 2'b00) begin
      if (sbq.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_rsp: rsp_valid %b with none expected at %0t", a_rsp_valid, $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_valid", 64'(a_rsp_valid), 64'(mon_e.valid));
        chk("rsp_data", 64'(a_rsp_data), 64'(mon_e.data));
        chk("rsp_last", 64'(a_rsp_last), 64'(mon_e.last));
      end
    end
  end

  typedef struct {
    logic [1:0]  valid;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mask;
    logic [7:0]  len;
    int          delay;
    logic [1:0]  exp_grant;
  } vec_t;

  vec_t vt[9];

  // Winner's slices carry the vector values, the loser's carry their complement
  task automatic drive_a(input vec_t v);
    int w;
    w = (v.exp_grant == 2'b10) ? 1 : ((v.exp_grant == 2'b01) ? 0 : -1);
    a_req_valid = v.valid;
    for (int i = 0; i < 2; i++) begin
      logic sel;
      sel = (i == w);
      a_req_write[i]          = sel ? v.wr    : ~v.wr;
      a_req_addr[i*32 +: 32]  = sel ? v.addr  : ~v.addr;
      a_req_wdata[i*32 +: 32] = sel ? v.wdata : ~v.wdata;
      a_req_mask[i*2 +: 2]    = sel ? v.mask  : ~v.mask;
      a_req_len[i*8 +: 8]     = sel ? v.len   : ~v.len;
    end
  endtask

  // Entered and left just after a rising edge
  task automatic run_vec(input vec_t v);
    rsp_t e;
    drive_a(v);
    @(negedge clock);
    chk("grant", 64'(a_req_ready), 64'(v.exp_grant));
    if (v.exp_grant == 2'b00) begin
      chk("idle_rvalid", 64'(a_mem_rvalid), 64'(0));
      chk("idle_wvalid", 64'(a_mem_wvalid), 64'(0));
      @(posedge clock); #1;
      return;
    end
    if (v.wr) begin
      e.valid = v.exp_grant; e.data = 32'h0; e.last = 1'b1;
      sbq.push_back(e);
    end else begin
      for (int b = 0; b <= int'(v.len); b++) begin
        e.valid = v.exp_grant; e.data = rd_model(v.addr, b); e.last = (b == int'(v.len));
        sbq.push_back(e);
      end
    end
    @(posedge clock); #1;
    a_req_valid = ~v.valid;
    a_req_write = ~a_req_write;
    a_req_addr  = ~a_req_addr;
    if (!v.wr) begin
      for (int b = 0; b <= int'(v.len); b++) begin
        if (b == 1) begin
          a_mem_rready = 1'b0;
          a_mem_rdata  = 32'hFFFF_FFFF;
          @(negedge clock);
          chk("rd_gap_rvalid", 64'(a_mem_rvalid), 64'(1));
          chk("rd_gap_rsp", 64'(a_rsp_valid), 64'(0));
          @(posedge clock); #1;
        end
        a_mem_rready = 1'b1;
        a_mem_rdata  = rd_model(v.addr, b);
        @(negedge clock);
        chk("mem_rvalid", 64'(a_mem_rvalid), 64'(1));
        chk("mem_wvalid_in_rd", 64'(a_mem_wvalid), 64'(0));
        chk("mem_raddr", 64'(a_mem_raddr), 64'(v.addr));
        chk("mem_rlen", 64'(a_mem_rlen), 64'(v.len));
        chk("mem_rmask", 64'(a_mem_rmask), 64'(v.mask));
        chk("ready_busy", 64'(a_req_ready), 64'(0));
        @(posedge clock); #1;
      end
      a_mem_rready = 1'b0;
      a_mem_rdata  = 32'h0;
    end else begin
      for (int d = 0; d < v.delay; d++) begin
        a_mem_wready = 1'b0;
        @(negedge clock);
        chk("wr_hold_wvalid", 64'(a_mem_wvalid), 64'(1));
        chk("wr_hold_rvalid", 64'(a_mem_rvalid), 64'(0));
        chk("wr_hold_waddr", 64'(a_mem_waddr), 64'(v.addr));
        chk("wr_hold_wdata", 64'(a_mem_wdata), 64'(v.wdata));
        chk("wr_hold_wmask", 64'(a_mem_wmask), 64'(v.mask));
        chk("wr_hold_rsp", 64'(a_rsp_valid), 64'(0));
        @(posedge clock); #1;
      end
      a_mem_wready = 1'b1;
      @(negedge clock);
      chk("wr_ack_wvalid", 64'(a_mem_wvalid), 64'(1));
      chk("ready_busy", 64'(a_req_ready), 64'(0));
      @(posedge clock); #1;
      a_mem_wready = 1'b0;
    end
    chk("sb_drained", 64'(sbq.size()), 64'(0));
    chk("done_rvalid", 64'(a_mem_rvalid), 64'(0));
    chk("done_wvalid", 64'(a_mem_wvalid), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rsp_t e;
    vec_t v;
    //          valid  wr    addr          wdata         mask   len   dly exp
    vt[0] = '{2'b11, 1'b0, 32'h1000_0040, 32'h0,        2'b10, 8'd0, 0, 2'b10};
    vt[1] = '{2'b11, 1'b0, 32'h8000_0000, 32'h0,        2'b10, 8'd3, 0, 2'b01};
    vt[2] = '{2'b11, 1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 2'b01, 8'd0, 5, 2'b10};
    vt[3] = '{2'b11, 1'b0, 32'h3000_0000, 32'h0,        2'b00, 8'd1, 0, 2'b01};
    vt[4] = '{2'b01, 1'b0, 32'h4000_0004, 32'h0,        2'b01, 8'd0, 0, 2'b01};
    vt[5] = '{2'b10, 1'b1, 32'h5000_0008, 32'h1234_5678, 2'b10, 8'd0, 0, 2'b10};
    vt[6] = '{2'b11, 1'b0, 32'h6000_0000, 32'h0,        2'b10, 8'd2, 0, 2'b01};
    vt[7] = '{2'b10, 1'b0, 32'h7000_0000, 32'h0,        2'b00, 8'd0, 0, 2'b10};
    vt[8] = '{2'b00, 1'b0, 32'h0,         32'h0,        2'b00, 8'd0, 0, 2'b00};

    reset = 1'b0;
    a_req_valid = 2'b11; a_req_write = '0; a_req_addr = '1; a_req_wdata = '1;
    a_req_mask = '0; a_req_len = '0;
    a_mem_rready = 1'b0; a_mem_rdata = '0; a_mem_wready = 1'b0;
    b_req_valid = '0; b_req_write = '0; b_req_addr = '0; b_req_wdata = '0;
    b_req_mask = '0; b_req_len = '0;
    b_mem_rready = 1'b0; b_mem_rdata = '0; b_mem_wready = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", 64'(a_req_ready), 64'(0));
    chk("rst_rvalid", 64'(a_mem_rvalid), 64'(0));
    chk("rst_wvalid", 64'(a_mem_wvalid), 64'(0));
    chk("rst_rsp", 64'(a_rsp_valid), 64'(0));
    @(posedge clock); #1;
    reset = 1'b1;
    a_req_valid = 2'b00;
    @(negedge clock);
    chk("rst_raddr", 64'(a_mem_raddr), 64'(0));
    chk("rst_rlen", 64'(a_mem_rlen), 64'(0));
    chk("rst_wdata", 64'(a_mem_wdata), 64'(0));
    @(posedge clock); #1;

    for (int n = 0; n < 9; n++) run_vec(vt[n]);

    // Abort a long burst owned by requester 1 after two beats
    v = '{2'b10, 1'b0, 32'hA000_0000, 32'h0, 2'b10, 8'd7, 0, 2'b10};
    drive_a(v);
    @(negedge clock);
    chk("abort_grant", 64'(a_req_ready), 64'(2'b10));
    for (int b = 0; b < 2; b++) begin
      e.valid = 2'b10; e.data = rd_model(v.addr, b); e.last = 1'b0;
      sbq.push_back(e);
    end
    @(posedge clock); #1;
    a_req_valid = 2'b00;
    for (int b = 0; b < 2; b++) begin
      a_mem_rready = 1'b1;
      a_mem_rdata  = rd_model(v.addr, b);
      @(posedge clock); #1;
    end
    chk("abort_sb_drained", 64'(sbq.size()), 64'(0));
    reset = 1'b0;
    a_mem_rready = 1'b0;
    @(posedge clock); #1;
    a_mem_rready = 1'b1;
    a_req_valid  = 2'b11;
    @(negedge clock);
    chk("abort_rvalid", 64'(a_mem_rvalid), 64'(0));
    chk("abort_rsp", 64'(a_rsp_valid), 64'(0));
    chk("abort_ready", 64'(a_req_ready), 64'(0));
    @(posedge clock); #1;
    reset = 1'b1;
    a_req_valid = 2'b00;
    @(negedge clock);
    chk("abort_raddr_clr", 64'(a_mem_raddr), 64'(0));
    chk("abort_rlen_clr", 64'(a_mem_rlen), 64'(0));
    chk("abort_rvalid2", 64'(a_mem_rvalid), 64'(0));
    @(posedge clock); #1;
    a_mem_rready = 1'b0;
    // Pointer cleared by reset: both valid must go to requester 1 again
    run_vec('{2'b11, 1'b0, 32'h9000_0000, 32'h0, 2'b01, 8'd0, 0, 2'b10});

    // Fixed priority: requester 1 keeps winning over 2 while it stays valid
    for (int i = 0; i < 3; i++) b_req_addr[i*32 +: 32] = 32'hB000_0000 + 32'(i * 16);
    for (int r = 0; r < 3; r++) begin
      b_req_valid = 3'b110;
      @(negedge clock);
      chk("fx_grant", 64'(b_req_ready), 64'(3'b010));
      @(posedge clock); #1;
      b_mem_rready = 1'b1;
      b_mem_rdata  = 32'hC0DE_0000 + 32'(r);
      @(negedge clock);
      chk("fx_rsp_valid", 64'(b_rsp_valid), 64'(3'b010));
      chk("fx_rsp_last", 64'(b_rsp_last), 64'(1));
      chk("fx_rsp_data", 64'(b_rsp_data), 64'(32'hC0DE_0000 + 32'(r)));
      chk("fx_raddr", 64'(b_mem_raddr), 64'(32'hB000_0010));
      @(posedge clock); #1;
      b_mem_rready = 1'b0;
    end
    b_req_valid = 3'b100;
    @(negedge clock);
    chk("fx_grant_only2", 64'(b_req_ready), 64'(3'b100));
    b_req_valid = 3'b111;
    #1;
    chk("fx_grant_all", 64'(b_req_ready), 64'(3'b001));
    b_req_valid = 3'b000;
    @(posedge clock); #1;
    @(negedge clock);
    chk("fx_idle_rvalid", 64'(b_mem_rvalid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/ysyx_25040111_rr_arbiter.md
YSYX_25040111_RR_ARBITER -- requirements
Module: ysyx_25040111_rr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2: number of requesters, 2..8.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have parameter PRIO_MODE, default 0: 0 = round-robin, 1 = fixed priority (index 0 highest).
REQ-005 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, NREQ bits: per-requester request valid.
REQ-008 SHALL have port req_ready, output, NREQ bits: per-requester request accept, one-hot or zero.
REQ-009 SHALL have port req_write, input, NREQ bits: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, NREQ*AW bits: packed addresses, requester i at slice [i*AW +: AW].
REQ-011 SHALL have port req_wdata, input, NREQ*DW bits: packed write data.
REQ-012 SHALL have port req_mask, input, NREQ*2 bits: packed access size (00 byte, 01 half, 10 word).
REQ-013 SHALL have port req_len, input, NREQ*8 bits: packed read beat count minus one; ignored for writes.
REQ-014 SHALL have port rsp_valid, output, NREQ bits: per-requester response beat, one-hot or zero.
REQ-015 SHALL have port rsp_last, output, 1 bit: final beat of the current transaction.
REQ-016 SHALL have port rsp_data, output, DW bits: read data shared by all requesters; 0 for write acks.
REQ-017 SHALL have port mem_rvalid, output, 1 bit: downstream read request valid.
REQ-018 SHALL have port mem_rready, input, 1 bit: downstream read beat returned; mem_rvalid & mem_rready is one beat.
REQ-019 SHALL have ports mem_raddr (output, AW), mem_rlen (output, 8) and mem_rmask (output, 2): latched read parameters.
REQ-020 SHALL have port mem_rdata, input, DW bits: downstream read data.
REQ-021 SHALL have port mem_wvalid, output, 1 bit: downstream write valid.
REQ-022 SHALL have port mem_wready, input, 1 bit: downstream write accept.
REQ-023 SHALL have ports mem_waddr (output, AW), mem_wdata (output, DW) and mem_wmask (output, 2): latched write parameters.

Function
REQ-024 SHALL implement FSM states IDLE, RD and WR.
REQ-025 SHALL arbitrate in IDLE only, combinationally among req_valid, and assert req_ready to the single winner in the same cycle; the request is accepted on req_valid & req_ready.
REQ-026 SHALL, on acceptance, latch owner index, addr, wdata, mask and len, and move to WR if req_write else RD; req_ready SHALL be 0 in RD and WR.
REQ-027 SHALL in round-robin mode search starting at index ptr+1 (mod NREQ) and set ptr to the winner on acceptance; ptr wraps from NREQ-1 to 0.
REQ-028 SHALL in fixed mode grant the lowest valid index; ptr SHALL be unused.
REQ-029 SHALL hold mem_rvalid=1 throughout RD with stable mem_raddr, mem_rlen and mem_rmask, and hold mem_wvalid=1 throughout WR; never both at once; both 0 in IDLE.
REQ-030 SHALL count read beats with an 8-bit counter cleared on entry to RD; each beat drives rsp_valid[owner]=1 and rsp_data=mem_rdata combinationally, with rsp_last=1 when count==len.
REQ-031 SHALL return from RD to IDLE on the last beat and from WR to IDLE on mem_wready; a write SHALL produce one rsp_valid[owner] pulse with rsp_last=1 in the mem_wready cycle.
REQ-032 SHALL take minimum latency from acceptance to the first downstream valid of 1 cycle, and SHALL NOT accept a new request in the same cycle as the completion of the previous one (at least 1 IDLE cycle).
REQ-033 SHALL ignore requester valid changes while busy; len=0 SHALL be a single-beat read.

Reset
REQ-034 SHALL, when reset=0 at a clock edge, enter IDLE, clear ptr, counter and all latched registers, and drive all outputs 0 from the next cycle, aborting any transaction in flight without a response.

Structure
REQ-035 SHALL place the state encoding and the mask encodings in shared package ysyx_25040111_mem_pkg; round-robin selection SHALL be the sub-module ysyx_25040111_rr_pick (valid vector and ptr in, one-hot grant out).

Verification
REQ-036 SHALL be verified with these directed scenarios:
- NREQ=2, round-robin, both requesting reads continuously after reset: grant order 1, 0, 1, 0.
- PRIO_MODE=1, req_valid=3'b110: requester 1 wins; requester 2 starves while requester 1 stays valid.
- Read with len=3, addr 0x8000_0000: exactly 4 rsp_valid[owner] beats, rsp_last only on the 4th beat, mem_rlen=3.
- Write with mask 01, data 0xDEAD_BEEF, mem_wready delayed 5 cycles: mem_wvalid held 5 cycles with stable parameters, then one ack pulse.
- reset=0 asserted mid-burst after beat 2: next cycle state is IDLE, mem_rvalid=0 and no further rsp_valid.
